mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline; the far end of the fetch redirect path.
- Holds the EX/MEM pipeline register and resolves branches.
- Drives EX_MEM_PCSrc and EX_MEM_NPC back into the fetch stage, and drives a flush to the younger latches.
- Contains the word-addressed data memory and the MEM/WB pipeline register that feeds write-back.

Parameters:
- DMEM_DEPTH, 256: number of 32-bit data-memory words; must be a power of two.
- DMEM_AW, 8: word-address width, equal to log2(DMEM_DEPTH).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX output is a real instruction (0 = bubble)
- ex_branch  in  1  instruction is a conditional branch
- ex_zero  in  1  ALU zero flag
- ex_memread  in  1  load
- ex_memwrite  in  1  store
- ex_regwrite  in  1  writes the register file
- ex_memtoreg  in  1  write-back selects memory data
- ex_alu_result  in  32  ALU result / byte address
- ex_rdata2  in  32  store data
- ex_branch_target  in  32  computed branch target
- ex_write_reg  in  5  destination register
- EX_MEM_PCSrc  out  1  taken-branch redirect select to fetch mux
- EX_MEM_NPC  out  32  redirect target to fetch mux
- flush  out  1  squash IF/ID and ID/EX loads this cycle
- mem_wb_valid, mem_wb_regwrite, mem_wb_memtoreg  out  1 each  write-back controls
- mem_wb_read_data  out  32  loaded word
- mem_wb_alu_result  out  32  forwarded ALU result
- mem_wb_write_reg  out  5  destination register

Behaviour:
- Reset (rst=1 at a rising edge): all EX/MEM and MEM/WB fields, including the valid bits, go to 0.
  - EX_MEM_PCSrc=0, EX_MEM_NPC=0 and flush=0 from the following cycle.
  - Data memory contents are not reset.
  - Reset asserted mid-redirect cancels the redirect; no store commits on a reset edge.
- EX/MEM register loads every edge:
  - exmem_valid <= ex_valid & ~EX_MEM_PCSrc.
  - All other fields load unconditionally.
- Branch resolution (combinational from EX/MEM):
  - EX_MEM_PCSrc = exmem_valid & exmem_branch & exmem_zero.
  - EX_MEM_NPC = exmem_branch_target.
  - flush = EX_MEM_PCSrc.
- Redirect timing:
  - The branch is in EX/MEM during cycle t; fetch loads the target at edge t.
  - The three younger wrong-path instructions are discarded at that edge: IF/ID and ID/EX via flush, EX via the exmem_valid gating.
  - Branch penalty is 3 cycles.
  - A redirect cannot repeat in t+1, because the EX/MEM entry is then a bubble.
- Data memory:
  - Word index = exmem_alu_result[DMEM_AW+1:2]. Bits [1:0] are ignored; upper bits are ignored, so addresses wrap modulo DMEM_DEPTH.
  - Write is synchronous at the edge when exmem_valid & exmem_memwrite.
  - Read is combinational from the current index when exmem_memread, else 0.
  - Simultaneous read and write to the same index returns the old value; the new value is stored.
  - Back-to-back store then load to the same index: the load returns the stored value.
- MEM/WB register loads every edge:
  - mem_wb_valid <= exmem_valid.
  - mem_wb_regwrite and mem_wb_memtoreg are gated by exmem_valid.
  - Data fields load unconditionally.
- Bubble rule: memwrite and regwrite have no effect when valid=0.
- Latency: EX input to MEM/WB output is 2 edges; redirect visible to fetch 1 edge after EX.

Optional Feature:
- Macro: MEM_STAGE_BRANCH_STATS_EN.
- With the macro:
  - Adds outputs br_total[31:0] (increments when exmem_valid & exmem_branch) and br_taken[31:0] (increments on EX_MEM_PCSrc).
  - Both reset to 0 and wrap at 2^32.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared pipeline package holds:
  - the EX/MEM and MEM/WB field bundle typedefs;
  - WORD_W=32 and REG_AW=5;
  - the DMEM_DEPTH default.
- One sub-module, data_mem: synchronous write, asynchronous read, parameterised by depth.
- Both latches and the branch logic stay in mem_stage.

Test Plan:
- Reset: rst high 2 cycles with ex_valid=1 and ex_branch=1 -> all outputs 0; a store presented during reset does not commit.
- Store/load: store 0xDEADBEEF to 0x10, then load 0x10 on the next cycle -> mem_wb_read_data=0xDEADBEEF 2 edges after the load enters; address 0x13 reads the same word.
- Wrap: store 0x12345678 at 0x400 with DMEM_DEPTH=256 -> a load of 0x000 returns 0x12345678.
- Taken branch: ex_branch=1, ex_zero=1, target=0x40 -> next cycle EX_MEM_PCSrc=1, EX_MEM_NPC=0x40, flush=1; the instruction entering EX/MEM that edge has mem_wb_valid=0 one edge later; PCSrc=0 the following cycle.
- Not taken: ex_branch=1, ex_zero=0 -> PCSrc=0, flush=0, no bubble inserted.
- Wrong-path store: a store directly behind a taken branch -> memory is unchanged and mem_wb_regwrite=0 (with stats: br_total=1, br_taken=1).

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: widths, data-memory
// default depth and the EX/MEM and MEM/WB latch bundles.
package mem_stage_pkg;

   localparam int unsigned WORD_W         = 32;
   localparam int unsigned REG_AW         = 5;
   localparam int unsigned DMEM_DEPTH_DEF = 256;

   typedef struct packed {
      logic              valid;
      logic              branch;
      logic              zero;
      logic              memread;
      logic              memwrite;
      logic              regwrite;
      logic              memtoreg;
      logic [WORD_W-1:0] alu_result;
      logic [WORD_W-1:0] rdata2;
      logic [WORD_W-1:0] branch_target;
      logic [REG_AW-1:0] write_reg;
   } exmem_t;

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic              memtoreg;
      logic [WORD_W-1:0] read_data;
      logic [WORD_W-1:0] alu_result;
      logic [REG_AW-1:0] write_reg;
   } memwb_t;

endpackage

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// A same-index read during a write returns the pre-edge contents.
import mem_stage_pkg::*;

module data_mem #(
   parameter int unsigned DEPTH = DMEM_DEPTH_DEF,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM latch, branch resolution and fetch redirect,
// data memory and MEM/WB latch. Define MEM_STAGE_BRANCH_STATS_EN to add the
// br_total / br_taken branch counters.
import mem_stage_pkg::*;

module mem_stage #(
   parameter int unsigned DMEM_DEPTH = DMEM_DEPTH_DEF,
   parameter int unsigned DMEM_AW    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              ex_branch,
   input  logic              ex_zero,
   input  logic              ex_memread,
   input  logic              ex_memwrite,
   input  logic              ex_regwrite,
   input  logic              ex_memtoreg,
   input  logic [WORD_W-1:0] ex_alu_result,
   input  logic [WORD_W-1:0] ex_rdata2,
   input  logic [WORD_W-1:0] ex_branch_target,
   input  logic [REG_AW-1:0] ex_write_reg,
   output logic              EX_MEM_PCSrc,
   output logic [WORD_W-1:0] EX_MEM_NPC,
   output logic              flush,
   output logic              mem_wb_valid,
   output logic              mem_wb_regwrite,
   output logic              mem_wb_memtoreg,
   output logic [WORD_W-1:0] mem_wb_read_data,
   output logic [WORD_W-1:0] mem_wb_alu_result,
   output logic [REG_AW-1:0] mem_wb_write_reg
`ifdef MEM_STAGE_BRANCH_STATS_EN
   ,
   output logic [31:0]       br_total,
   output logic [31:0]       br_taken
`endif
);

   exmem_t              exmem, exmem_d;
   memwb_t              memwb, memwb_d;
   logic [DMEM_AW-1:0]  dm_index;
   logic [WORD_W-1:0]   dm_rdata;
   logic                dm_we;
   logic                unused_addr_bits;

   // The instruction in EX is wrong-path whenever a redirect is being taken.
   always_comb begin
      exmem_d               = '0;
      exmem_d.valid         = ex_valid & ~EX_MEM_PCSrc;
      exmem_d.branch        = ex_branch;
      exmem_d.zero          = ex_zero;
      exmem_d.memread       = ex_memread;
      exmem_d.memwrite      = ex_memwrite;
      exmem_d.regwrite      = ex_regwrite;
      exmem_d.memtoreg      = ex_memtoreg;
      exmem_d.alu_result    = ex_alu_result;
      exmem_d.rdata2        = ex_rdata2;
      exmem_d.branch_target = ex_branch_target;
      exmem_d.write_reg     = ex_write_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) exmem <= '0;
      else     exmem <= exmem_d;
   end

   assign EX_MEM_PCSrc = exmem.valid & exmem.branch & exmem.zero;
   assign EX_MEM_NPC   = exmem.branch_target;
   assign flush        = EX_MEM_PCSrc;

   // Byte offset and upper address bits are dropped, so addresses wrap.
   assign dm_index         = exmem.alu_result[DMEM_AW+1:2];
   assign unused_addr_bits = ^{exmem.alu_result[WORD_W-1:DMEM_AW+2], exmem.alu_result[1:0]};
   assign dm_we            = exmem.valid & exmem.memwrite & ~rst;

   data_mem #(
      .DEPTH (DMEM_DEPTH),
      .AW    (DMEM_AW)
   ) u_data_mem (
      .clk   (clk),
      .we    (dm_we),
      .addr  (dm_index),
      .wdata (exmem.rdata2),
      .rdata (dm_rdata)
   );

   always_comb begin
      memwb_d            = '0;
      memwb_d.valid      = exmem.valid;
      memwb_d.regwrite   = exmem.valid & exmem.regwrite;
      memwb_d.memtoreg   = exmem.valid & exmem.memtoreg;
      memwb_d.read_data  = exmem.memread ? dm_rdata : '0;
      memwb_d.alu_result = exmem.alu_result;
      memwb_d.write_reg  = exmem.write_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) memwb <= '0;
      else     memwb <= memwb_d;
   end

   assign mem_wb_valid      = memwb.valid;
   assign mem_wb_regwrite   = memwb.regwrite;
   assign mem_wb_memtoreg   = memwb.memtoreg;
   assign mem_wb_read_data  = memwb.read_data;
   assign mem_wb_alu_result = memwb.alu_result;
   assign mem_wb_write_reg  = memwb.write_reg;

`ifdef MEM_STAGE_BRANCH_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         br_total <= '0;
         br_taken <= '0;
      end else begin
         if (exmem.valid & exmem.branch) br_total <= br_total + 32'd1;
         if (EX_MEM_PCSrc)               br_taken <= br_taken + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB results are queued when an
// instruction is presented to EX and compared when it reaches MEM/WB.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_branch, ex_zero, ex_memread, ex_memwrite;
   logic        ex_regwrite, ex_memtoreg;
   logic [31:0] ex_alu_result, ex_rdata2, ex_branch_target;
   logic [4:0]  ex_write_reg;
   logic        EX_MEM_PCSrc, flush;
   logic [31:0] EX_MEM_NPC;
   logic        mem_wb_valid, mem_wb_regwrite, mem_wb_memtoreg;
   logic [31:0] mem_wb_read_data, mem_wb_alu_result;
   logic [4:0]  mem_wb_write_reg;
`ifdef MEM_STAGE_BRANCH_STATS_EN
   logic [31:0] br_total, br_taken;
`endif

   mem_stage #(.DMEM_DEPTH(256), .DMEM_AW(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .ex_valid         (ex_valid),
      .ex_branch        (ex_branch),
      .ex_zero          (ex_zero),
      .ex_memread       (ex_memread),
      .ex_memwrite      (ex_memwrite),
      .ex_regwrite      (ex_regwrite),
      .ex_memtoreg      (ex_memtoreg),
      .ex_alu_result    (ex_alu_result),
      .ex_rdata2        (ex_rdata2),
      .ex_branch_target (ex_branch_target),
      .ex_write_reg     (ex_write_reg),
      .EX_MEM_PCSrc     (EX_MEM_PCSrc),
      .EX_MEM_NPC       (EX_MEM_NPC),
      .flush            (flush),
      .mem_wb_valid     (mem_wb_valid),
      .mem_wb_regwrite  (mem_wb_regwrite),
      .mem_wb_memtoreg  (mem_wb_memtoreg),
      .mem_wb_read_data (mem_wb_read_data),
      .mem_wb_alu_result(mem_wb_alu_result),
      .mem_wb_write_reg (mem_wb_write_reg)
`ifdef MEM_STAGE_BRANCH_STATS_EN
      ,
      .br_total         (br_total),
      .br_taken         (br_taken)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          valid, branch, zero, mr, mw, rw, m2r;
      logic [31:0] alu, wdata, tgt;
      logic [4:0]  wr;
   } instr_t;

   typedef struct {
      bit          valid, rw, m2r;
      logic [31:0] rd, alu;
      logic [4:0]  wr;
   } exp_t;

   exp_t        q[$];
   logic [31:0] model_mem [int];
   bit          squash_next;
   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [31:0] m_total, m_taken;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic instr_t nop();
      instr_t i = '{default: '0};
      return i;
   endfunction

   function automatic instr_t st(input logic [31:0] a, input logic [31:0] d);
      instr_t i = nop();
      i.valid = 1; i.mw = 1; i.alu = a; i.wdata = d;
      return i;
   endfunction

   function automatic instr_t ld(input logic [31:0] a, input logic [4:0] r);
      instr_t i = nop();
      i.valid = 1; i.mr = 1; i.rw = 1; i.m2r = 1; i.alu = a; i.wr = r;
      return i;
   endfunction

   function automatic instr_t alu(input logic [31:0] v, input logic [4:0] r);
      instr_t i = nop();
      i.valid = 1; i.rw = 1; i.alu = v; i.wr = r;
      return i;
   endfunction

   function automatic instr_t br(input bit z, input logic [31:0] t);
      instr_t i = nop();
      i.valid = 1; i.branch = 1; i.zero = z; i.tgt = t;
      return i;
   endfunction

   task automatic drive(input instr_t i);
      ex_valid = i.valid; ex_branch = i.branch; ex_zero = i.zero;
      ex_memread = i.mr; ex_memwrite = i.mw; ex_regwrite = i.rw;
      ex_memtoreg = i.m2r; ex_alu_result = i.alu; ex_rdata2 = i.wdata;
      ex_branch_target = i.tgt; ex_write_reg = i.wr;
   endtask

   task automatic cyc(input instr_t i);
      exp_t e;
      bit   ev, pc;
      int   idx;
      drive(i);
      ev  = i.valid & ~squash_next;
      pc  = ev & i.branch & i.zero;
      idx = int'(i.alu[9:2]);
      e.valid = ev; e.rw = ev & i.rw; e.m2r = ev & i.m2r;
      e.alu = i.alu; e.wr = i.wr;
      e.rd  = '0;
      if (i.mr) e.rd = model_mem.exists(idx) ? model_mem[idx] : 32'hx;
      if (ev && i.mw) model_mem[idx] = i.wdata;
      if (ev && i.branch) m_total++;
      if (pc) m_taken++;
      squash_next = pc;
      q.push_back(e);
      @(posedge clk); #1;
      check("pcsrc", {31'd0, EX_MEM_PCSrc}, {31'd0, pc});
      check("flush", {31'd0, flush}, {31'd0, pc});
      check("npc", EX_MEM_NPC, i.tgt);
      if (q.size() == 2) begin
         e = q.pop_front();
         check("wb_valid", {31'd0, mem_wb_valid}, {31'd0, e.valid});
         check("wb_regwrite", {31'd0, mem_wb_regwrite}, {31'd0, e.rw});
         check("wb_memtoreg", {31'd0, mem_wb_memtoreg}, {31'd0, e.m2r});
         if (e.rd !== 32'hx) check("wb_read_data", mem_wb_read_data, e.rd);
         check("wb_alu", mem_wb_alu_result, e.alu);
         check("wb_wreg", {27'd0, mem_wb_write_reg}, {27'd0, e.wr});
      end
   endtask

   task automatic reset_check();
      check("rst_pcsrc", {31'd0, EX_MEM_PCSrc}, 32'd0);
      check("rst_npc", EX_MEM_NPC, 32'd0);
      check("rst_flush", {31'd0, flush}, 32'd0);
      check("rst_wb_valid", {31'd0, mem_wb_valid}, 32'd0);
      check("rst_wb_regwrite", {31'd0, mem_wb_regwrite}, 32'd0);
      check("rst_wb_read_data", mem_wb_read_data, 32'd0);
      check("rst_wb_alu", mem_wb_alu_result, 32'd0);
`ifdef MEM_STAGE_BRANCH_STATS_EN
      check("rst_br_total", br_total, 32'd0);
      check("rst_br_taken", br_taken, 32'd0);
`endif
   endtask

   task automatic do_reset(input instr_t i);
      drive(i);
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      reset_check();
      q.delete();
      squash_next = 0;
      m_total = '0;
      m_taken = '0;
      rst = 0;
   endtask

   initial begin
      squash_next = 0;
      m_total = '0;
      m_taken = '0;
      drive(nop());
      rst = 1;
      #1;
      // Reset with a taken branch and a store sitting at EX.
      do_reset(br(1, 32'h80));
      do_reset(st(32'h10, 32'h0BAD0BAD));

      cyc(st(32'h10, 32'hDEADBEEF));
      cyc(ld(32'h10, 5'd3));
      cyc(ld(32'h13, 5'd4));
      cyc(st(32'h400, 32'h12345678));
      cyc(ld(32'h000, 5'd5));
      cyc(alu(32'h55, 5'd6));

      cyc(br(1, 32'h40));
      cyc(alu(32'h77, 5'd7));
      cyc(alu(32'h88, 5'd8));

      cyc(br(0, 32'h60));
      cyc(alu(32'h99, 5'd9));

      cyc(st(32'h20, 32'h11111111));
      cyc(br(1, 32'hA0));
      cyc(st(32'h20, 32'h00BADBAD));
      cyc(ld(32'h20, 5'd10));
      cyc(nop());
      cyc(nop());
`ifdef MEM_STAGE_BRANCH_STATS_EN
      check("br_total", br_total, m_total);
      check("br_taken", br_taken, m_taken);
`endif

      // A store in EX/MEM when reset hits must not commit.
      drive(st(32'h20, 32'h0000CAFE));
      @(posedge clk); #1;
      do_reset(nop());
      cyc(ld(32'h20, 5'd11));
      cyc(ld(32'h10, 5'd12));
      cyc(nop());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
